// File: rtl/lsu_dmem_responder.sv
// lsu_dmem_responder: word-addressed data memory that answers CPU load/store requests after LATENCY wait cycles.
// A simultaneous read and write is served write-first; the held read is taken on the next IDLE cycle.
module lsu_dmem_responder #(
    parameter int ADDR_WIDTH_D = 10,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rready_cpu,
    output logic        rvalid_cpu,
    input  logic        wvalid_cpu,
    output logic        wready_cpu,
    input  logic [3:0]  strb_cpu,
    input  logic [31:0] addr_cpu,
    input  logic [31:0] data_cpu_o,
    output logic [31:0] data_cpu_i,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
    state_t state, nxt;
    logic [3:0] cnt;
    logic [ADDR_WIDTH_D-1:0] idx, idx_sel;
    logic [3:0] strb;
    logic [31:0] wdata;
    logic is_wr, wr_sel, rv_q, wr_q;
    logic [31:0] mem [2**ADDR_WIDTH_D];
    logic unused_addr;
    assign unused_addr = ^{addr_cpu[31:ADDR_WIDTH_D+2], addr_cpu[1:0]};
    assign wr_sel = (state == IDLE) ? wvalid_cpu : is_wr;
    assign idx_sel = (state == IDLE) ? addr_cpu[ADDR_WIDTH_D+1:2] : idx;
    always_comb begin
        nxt = (state == IDLE) ? ((rready_cpu || wvalid_cpu) ? ((LATENCY == 0) ? RESP : WAIT) : IDLE)
            : (state == WAIT) ? ((cnt == 4'd0) ? RESP : WAIT) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= 4'd0;
            idx <= '0;
            strb <= 4'd0;
            wdata <= 32'd0;
            is_wr <= 1'b0;
            rv_q <= 1'b0;
            wr_q <= 1'b0;
            data_cpu_i <= 32'd0;
        end else begin
            state <= nxt;
            if (state == IDLE && nxt != IDLE) begin
                idx <= addr_cpu[ADDR_WIDTH_D+1:2];
                strb <= strb_cpu;
                wdata <= data_cpu_o;
                is_wr <= wvalid_cpu;
                cnt <= LAT_M1;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            rv_q <= (nxt == RESP) && !wr_sel;
            wr_q <= (nxt == RESP) && wr_sel;
            if (nxt == RESP && !wr_sel)
                data_cpu_i <= mem[idx_sel];
        end
    end
    // Memory has no reset; a reset during RESP suppresses the pending write.
    always_ff @(posedge clk) begin
        if (rst_n && state == RESP && is_wr)
            for (int i = 0; i < 4; i++)
                if (strb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
    // Gating by rst_n keeps a reset asserted in RESP from showing a response pulse.
    assign rvalid_cpu = rv_q && rst_n;
    assign wready_cpu = wr_q && rst_n;
    assign busy = state != IDLE;
endmodule

// File: doc/lsu_dmem_responder.md
LSU_DMEM_RESPONDER -- requirements
Module: lsu_dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH_D, default 10, giving the word-address width; depth is 2**ADDR_WIDTH_D 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 1, giving wait cycles between request acceptance and response; legal range 0..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port rready_cpu, input, 1 bit: read request level from the CPU.
REQ-006 SHALL have port rvalid_cpu, output, 1 bit: one-cycle read-response pulse.
REQ-007 SHALL have port wvalid_cpu, input, 1 bit: write request level from the CPU.
REQ-008 SHALL have port wready_cpu, output, 1 bit: one-cycle write-response pulse.
REQ-009 SHALL have port strb_cpu, input, 4 bits: byte write strobes, where bit i enables byte lane i (data bits 8i+7:8i).
REQ-010 SHALL have port addr_cpu, input, 32 bits: byte address.
REQ-011 SHALL have port data_cpu_o, input, 32 bits: write data.
REQ-012 SHALL have port data_cpu_i, output, 32 bits: read data.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-015 SHALL accept a request only in IDLE when rready_cpu or wvalid_cpu is high.
- On acceptance, latch word index addr_cpu[ADDR_WIDTH_D+1:2], strb_cpu, data_cpu_o and the request type.
REQ-016 SHALL ignore addr_cpu[1:0] and addr_cpu[31:ADDR_WIDTH_D+2]; out-of-range addresses wrap modulo depth.
REQ-017 SHALL, when rready_cpu and wvalid_cpu are both high in IDLE, accept the write first; the still-held read is accepted in the IDLE cycle after the write response.
REQ-018 SHALL on acceptance:
- with LATENCY=0, go directly to RESP;
- otherwise go to WAIT, load a 4-bit counter with LATENCY-1, decrement it each WAIT cycle, and go to RESP in the cycle after it reads 0.
REQ-019 SHALL produce the response pulse in cycle A+1+LATENCY, where A is the acceptance cycle.
REQ-020 SHALL in RESP drive exactly one of rvalid_cpu or wready_cpu high for one cycle, then return to IDLE.
REQ-021 SHALL for a read drive data_cpu_i with the memory word at the latched index in the RESP cycle, and hold that value until the next read response.
REQ-022 SHALL for a write update only the byte lanes whose latched strobe bit is 1, on the clock edge ending the RESP cycle.
REQ-023 SHALL complete the handshake for strb=0000 normally, leaving memory unchanged.
REQ-024 SHALL make a read that follows a write to the same word return the written value.
REQ-025 SHALL ignore request-input changes during WAIT and RESP; latched values are used.
REQ-026 SHALL treat a request still high in the IDLE cycle after a response as a new request.
REQ-027 SHALL keep rvalid_cpu and wready_cpu low outside RESP.

Reset
REQ-028 SHALL, when rst_n is low at a clock edge, set the FSM to IDLE and set the counter, rvalid_cpu, wready_cpu, data_cpu_i and all latched fields to 0.
REQ-029 SHALL NOT reset memory contents; they are undefined until written.
REQ-030 SHALL on reset mid-operation abort the transaction: no response pulse and no memory write, including when reset is asserted in RESP.

Verification
REQ-031 SHALL cover: LATENCY=1, write 0xDEADBEEF to 0x40 with strb=1111, accepted in cycle 0 -> wready_cpu=1 only in cycle 2; then a read of 0x40 -> data_cpu_i=0xDEADBEEF with rvalid_cpu pulse.
REQ-032 SHALL cover: word 0x40=0xDEADBEEF, write 0x11223344 with strb=0101 -> a later read returns 0xDE22BE44.
REQ-033 SHALL cover: LATENCY=0, read 0x0 -> rvalid_cpu in cycle A+1; with ADDR_WIDTH_D=10, a write to 0x1000 then a read of 0x0 -> same data (wrap).
REQ-034 SHALL cover: rready_cpu and wvalid_cpu both high in IDLE at 0x8 with data 0x5 -> wready_cpu pulse first, then rvalid_cpu with data_cpu_i=0x5.
REQ-035 SHALL cover: LATENCY=3, write 0xAA to 0x4, rst_n low in WAIT -> no wready_cpu, busy=0, and a re-read of 0x4 after reset returns the prior contents.
REQ-036 SHALL cover: addr_cpu and data_cpu_o changed during WAIT -> the latched address and data are used.
